if_fetch_ctrl: RTL

Instruction-fetch sequencer sitting between the pipeline PC logic and the instruction memory (im). Owns the fetch PC and issues word requests over a req/valid handshake that tolerates multi-cycle memory latency. Buffers fetched words in a small FIFO toward the ID stage. Handles decode back-pressure and branch/jump redirects, discarding wrong-path instructions.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/if_fetch_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants: FSM encodings, instruction size,
// the bubble word, and the {pc, inst} entry carried through the fetch queue.
package mips_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,   // no request outstanding
      S_WAIT  = 2'd1,   // request outstanding, response will be kept
      S_DRAIN = 2'd2    // request outstanding, response will be thrown away
   } fetch_state_t;

   localparam int unsigned INST_BYTES = 4;
   localparam logic [31:0] NOP        = 32'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Clear the byte-offset bits so any address lands on a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'(INST_BYTES - 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetched {pc, inst} entries between fetch and decode.
// Pointers wrap naturally; flush empties the queue in one cycle. The head
// entry is presented combinationally and reads as zero when empty.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_push,
   input  fetch_entry_t  i_entry,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty,
   output fetch_entry_t  o_head
);

   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   // Pointer and occupancy update; flush discards everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + 1'b1;
         if (i_pop)  r_head <= r_head + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (!reset && !i_flush && i_push) r_mem[r_tail] <= i_entry;
   end

   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == LP_DEPTH);
   assign o_head  = o_empty ? '{pc: 32'h0, inst: NOP} : r_mem[r_head];

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one word request
// at a time to instruction memory, buffers responses toward decode and
// handles redirects. A request is only launched when the queue is
// guaranteed to have room for its response, so the queue never overflows.
module if_fetch_ctrl
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_valid,
   input  logic [31:0] mem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out
);

   localparam int          CW       = $clog2(DEPTH) + 1;
   localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

   fetch_state_t r_state;
   logic         r_mem_req;
   logic [31:0]  r_mem_addr;
   logic [31:0]  r_fetch_pc;

   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [CW:0]   w_count_after;
   logic          w_room_next;
   logic [31:0]   w_next_pc;
   logic [31:0]   w_redirect_pc;
   fetch_entry_t  w_push_entry;
   fetch_entry_t  w_head;

   // Redirect beats both pop and push: the head is wrong-path, and so is
   // any response landing in the same cycle.
   assign w_pop  = !w_empty && id_ready && !redirect_valid;
   assign w_push = (r_state == S_WAIT) && mem_valid && !redirect_valid;

   // Occupancy after this cycle's push/pop; if it leaves a free slot the
   // next request may go out back-to-back with the response.
   assign w_count_after = {1'b0, w_count} + {{CW{1'b0}}, w_push}
                                          - {{CW{1'b0}}, w_pop};
   assign w_room_next   = (w_count_after < LP_DEPTH);

   assign w_next_pc     = r_fetch_pc + 32'(INST_BYTES);
   assign w_redirect_pc = word_align(redirect_pc);
   assign w_push_entry  = '{pc: r_mem_addr, inst: mem_rdata};

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_entry (w_push_entry),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   // Request FSM with registered mem_req/mem_addr. In S_WAIT and S_DRAIN
   // the request address equals the address being waited on; S_DRAIN is the
   // "discard the next response" condition left behind by a redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_addr <= RESET_PC;
         r_fetch_pc <= RESET_PC;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (redirect_valid) begin
                  r_fetch_pc <= w_redirect_pc;
               end else if (!w_full) begin
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= r_fetch_pc;
                  r_state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  r_fetch_pc <= w_redirect_pc;
                  if (mem_valid) begin
                     // response is wrong-path; request already retired
                     r_mem_req <= 1'b0;
                     r_state   <= S_IDLE;
                  end else begin
                     // request cannot be withdrawn; keep it up and drop its data
                     r_state   <= S_DRAIN;
                  end
               end else if (mem_valid) begin
                  r_fetch_pc <= w_next_pc;
                  if (w_room_next) begin
                     r_mem_addr <= w_next_pc;
                  end else begin
                     r_mem_req <= 1'b0;
                     r_state   <= S_IDLE;
                  end
               end
            end
            S_DRAIN: begin
               if (redirect_valid) r_fetch_pc <= w_redirect_pc;
               if (mem_valid) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_req    = r_mem_req;
   assign mem_addr   = r_mem_addr;
   assign inst_valid = !w_empty;
   assign inst_out   = w_head.inst;
   assign pc_out     = w_head.pc;

endmodule
